// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction memory
// and presents fetched words in an IF/ID register, with a one-entry stall buffer and branch flush.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ReadInstruction,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] redirect_pc;

  assign redirect_pc     = branch_target & 32'hFFFF_FFFC;
  assign imem_req        = (state_q != BOOT) && !stall && !branch_taken;
  assign imem_addr       = pc_q;
  assign ReadInstruction = instr_q;
  assign if_pc           = if_pc_q;
  assign if_valid        = if_valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = 1'b0;
    pend_pc_d   = pend_pc_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    instr_d     = instr_q;
    if_pc_d     = if_pc_q;
    if_valid_d  = if_valid_q;

    if (imem_req) begin
      pend_d    = 1'b1;
      pend_pc_d = pc_q;
      pc_d      = pc_q + 32'd4;
    end

    // A redirect overrides everything, including a stall; data for older requests is dropped.
    if (branch_taken) begin
      pc_d        = redirect_pc;
      pend_d      = 1'b0;
      buf_valid_d = 1'b0;
      state_d     = RUN;
      instr_d     = NOP_INSTR;
      if_valid_d  = 1'b0;
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (pend_q && !stall) begin
            instr_d    = imem_rdata;
            if_pc_d    = pend_pc_q;
            if_valid_d = 1'b1;
          end else if (pend_q && stall) begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pend_pc_q;
            buf_valid_d = 1'b1;
            state_d     = HOLD;
          end else if (!stall) begin
            instr_d    = NOP_INSTR;
            if_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d     = buf_valid_q ? buf_instr_q : NOP_INSTR;
            if_pc_d     = buf_valid_q ? buf_pc_q : if_pc_q;
            if_valid_d  = buf_valid_q;
            buf_valid_d = 1'b0;
            state_d     = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= PC_RESET;
      pend_q      <= 1'b0;
      pend_pc_q   <= 32'h0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= 32'h0;
      buf_pc_q    <= 32'h0;
      instr_q     <= NOP_INSTR;
      if_pc_q     <= 32'h0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      instr_q     <= instr_d;
      if_pc_q     <= if_pc_d;
      if_valid_q  <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed stall/branch/reset sequences plus a
// second instance started near the top of the address space to exercise PC wrap.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, imem_rdata, ReadInstruction, if_pc;

  logic        imem_req2, if_valid2;
  logic [31:0] imem_addr2, imem_rdata2, ReadInstruction2, if_pc2;

  int   checks = 0;
  int   failures = 0;
  exp_t expQ[$];
  exp_t expQ2[$];
  logic stallAtEdge = 1'b0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .ReadInstruction(ReadInstruction), .if_pc(if_pc),
    .if_valid(if_valid)
  );

  instr_fetch_unit #(.PC_RESET(32'hFFFF_FFF8)) dutWrap (
    .clk(clk), .rst(rst), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .ReadInstruction(ReadInstruction2), .if_pc(if_pc2),
    .if_valid(if_valid2)
  );

  always #5 clk = ~clk;

  // Memory word at any address is 0x1000_0000 | addr, returned one cycle after the request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 32'h1000_0000 | imem_addr;
    if (imem_req2) imem_rdata2 <= 32'h1000_0000 | imem_addr2;
    stallAtEdge <= stall;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushRange(input logic [31:0] firstPc, input int count);
    for (int i = 0; i < count; i++)
      expQ.push_back('{instr: 32'h1000_0000 | (firstPc + 32'(4 * i)), pc: firstPc + 32'(4 * i)});
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic s, input logic b, input logic [31:0] tgt);
    stall         = s;
    branch_taken  = b;
    branch_target = tgt;
  endtask

  // A word is newly presented when IF/ID is valid and was not frozen by a stall at the last edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && if_valid && !stallAtEdge) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_word actual_pc=%h actual_instr=%h required=none", if_pc, ReadInstruction);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_pc", if_pc, e.pc);
        checkOutput("sb_instr", ReadInstruction, e.instr);
      end
    end
    if (!rst && if_valid2 && expQ2.size() != 0) begin
      e = expQ2.pop_front();
      checkOutput("wrap_pc", if_pc2, e.pc);
      checkOutput("wrap_instr", ReadInstruction2, e.instr);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    waitEdges(2);
    #1;
    checkOutput("reset_instr", ReadInstruction, NOP);
    checkOutput("reset_pc", if_pc, 32'h0);
    checkOutput("reset_valid", 32'(if_valid), 32'h0);
    checkOutput("reset_req", 32'(imem_req), 32'h0);

    pushRange(32'h0, 9);
    expQ2.push_back('{instr: 32'hFFFF_FFF8, pc: 32'hFFFF_FFF8});
    expQ2.push_back('{instr: 32'hFFFF_FFFC, pc: 32'hFFFF_FFFC});
    expQ2.push_back('{instr: 32'h1000_0000, pc: 32'h0000_0000});
    rst = 1'b0;
    #1;
    checkOutput("boot_no_req", 32'(imem_req), 32'h0);
    waitEdges(1);
    #1;
    checkOutput("first_req", 32'(imem_req), 32'h1);
    checkOutput("first_addr", imem_addr, 32'h0);

    // Stall arrives with the returning data for PC 8 and lasts three cycles.
    waitEdges(3);
    applyStimulus(1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("stall_req0", 32'(imem_req), 32'h0);
    for (int i = 1; i < 3; i++) begin
      waitEdges(1);
      #1;
      checkOutput("stall_hold_pc", if_pc, 32'h4);
      checkOutput("stall_hold_valid", 32'(if_valid), 32'h1);
      checkOutput("stall_req", 32'(imem_req), 32'h0);
    end
    waitEdges(1);
    checkOutput("stall_last_pc", if_pc, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("release_req", 32'(imem_req), 32'h1);
    checkOutput("release_addr", imem_addr, 32'hC);

    waitEdges(7);
    checkOutput("pre_branch_pc", if_pc, 32'h20);
    applyStimulus(1'b0, 1'b1, 32'h0000_0102);
    #1;
    checkOutput("branch_req", 32'(imem_req), 32'h0);
    waitEdges(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    pushRange(32'h100, 3);
    #1;
    checkOutput("bubble1_valid", 32'(if_valid), 32'h0);
    checkOutput("bubble1_instr", ReadInstruction, NOP);
    checkOutput("bubble1_pc", if_pc, 32'h20);
    checkOutput("target_addr", imem_addr, 32'h100);
    checkOutput("target_req", 32'(imem_req), 32'h1);
    waitEdges(1);
    checkOutput("bubble2_valid", 32'(if_valid), 32'h0);
    checkOutput("bubble2_instr", ReadInstruction, NOP);

    // Redirect while a word sits in the hold buffer.
    waitEdges(3);
    applyStimulus(1'b1, 1'b0, 32'h0);
    waitEdges(1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0203);
    #1;
    checkOutput("hold_branch_req", 32'(imem_req), 32'h0);
    waitEdges(1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    pushRange(32'h200, 3);
    #1;
    checkOutput("hold_flush_valid", 32'(if_valid), 32'h0);
    checkOutput("hold_target_addr", imem_addr, 32'h200);
    checkOutput("hold_stalled_req", 32'(imem_req), 32'h0);
    waitEdges(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("hold_target_req", 32'(imem_req), 32'h1);
    waitEdges(1);
    checkOutput("hold_bubble_valid", 32'(if_valid), 32'h0);

    // Asynchronous reset between edges while the fetch of 0x20C is outstanding.
    waitEdges(3);
    #5;
    checkOutput("pre_reset_valid", 32'(if_valid), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("async_instr", ReadInstruction, NOP);
    checkOutput("async_pc", if_pc, 32'h0);
    checkOutput("async_valid", 32'(if_valid), 32'h0);
    checkOutput("async_req", 32'(imem_req), 32'h0);
    checkOutput("drain_before_reset", 32'(expQ.size()), 32'h0);

    waitEdges(2);
    pushRange(32'h0, 3);
    rst = 1'b0;
    waitEdges(2);
    #1;
    checkOutput("restart_edge2_valid", 32'(if_valid), 32'h0);
    waitEdges(1);
    #1;
    checkOutput("restart_edge3_valid", 32'(if_valid), 32'h1);
    checkOutput("restart_edge3_pc", if_pc, 32'h0);
    checkOutput("restart_edge3_instr", ReadInstruction, 32'h1000_0000);
    waitEdges(2);
    #4;
    checkOutput("final_drain", 32'(expQ.size()), 32'h0);
    checkOutput("wrap_drain", 32'(expQ2.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the CPU, directly upstream of the decode/main control logic.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Presents each fetched word plus its PC in an IF/ID output register (ReadInstruction, if_pc, if_valid), which feeds decode.
- Handles decode stalls with a one-entry hold buffer, and branch redirects with a flush.

Parameters:
- PC_RESET, 32'h0000_0000, PC of the first fetch after reset.
- NOP_INSTR, 32'h0000_0013, word driven on ReadInstruction during bubbles (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- stall  in  1  decode/hazard request to freeze the IF/ID register.
- branch_taken  in  1  redirect request, valid for one cycle.
- branch_target  in  32  redirect PC; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  read strobe; data returns on imem_rdata in the next cycle.
- imem_addr  out  32  read address, equal to the pc register (combinational).
- imem_rdata  in  32  read data, valid the cycle after imem_req.
- ReadInstruction  out  32  IF/ID instruction register.
- if_pc  out  32  IF/ID PC of ReadInstruction.
- if_valid  out  1  ReadInstruction holds a real instruction.

Behaviour:
- Reset (async, immediate):
  - pc=PC_RESET, state=BOOT, pend=0, buf_valid=0.
  - ReadInstruction=NOP_INSTR, if_pc=0, if_valid=0.
  - imem_req=0 while rst=1.
- Internal registers: pc, pend (a request was issued last cycle), pend_pc, buf_valid/buf_instr/buf_pc, state ∈ {BOOT, RUN, HOLD}.
- imem_req = (state!=BOOT) && !stall && !branch_taken.
  - When a request is issued: pend<=1, pend_pc<=pc, pc<=pc+4 (32-bit wrap: FFFF_FFFC -> 0000_0000).
  - Otherwise pend<=0.
- BOOT: one cycle, no request, then go to RUN. branch_taken in BOOT is applied (see redirect rule).
- RUN:
  - pend && !stall: IF/ID <= {imem_rdata, pend_pc, 1}.
  - pend && stall: buf <= {imem_rdata, pend_pc}, buf_valid<=1, go to HOLD; IF/ID holds.
  - !pend && !stall: IF/ID <= {NOP_INSTR, if_pc unchanged, 0} (bubble).
  - !pend && stall: IF/ID holds.
- HOLD:
  - stall=1: everything holds; no request is issued.
  - stall=0: IF/ID <= {buf_instr, buf_pc, 1}, buf_valid<=0, go to RUN. A request at pc is issued in the same cycle, so there is no bubble.
- Redirect (branch_taken=1, highest priority in every state, including during stall):
  - pc <= {branch_target[31:2], 2'b00}, pend<=0, buf_valid<=0, state<=RUN.
  - IF/ID <= {NOP_INSTR, if_pc unchanged, 0}.
  - Any imem_rdata returning for an older request is discarded.
  - The target instruction is fetched in the next cycle and appears on IF/ID after the 2nd rising edge following the branch edge (2 bubble cycles).
- Startup latency: the first valid instruction (at PC_RESET) is visible after the 3rd rising edge following rst deassertion.
- Steady state, no stall: one instruction per cycle, consecutive if_pc values differ by 4.
- rst asserted mid-operation: all state returns to reset values at once; the in-flight fetch is dropped.
- Invariant: at most one outstanding request and at most one buffered word; no instruction is ever lost or duplicated across stalls.

Test Plan:
- Reset release, memory holds word = 0x1000_0000|addr:
  - imem_req first high in the 2nd cycle with addr 0.
  - if_valid rises after the 3rd edge with ReadInstruction=0x1000_0000, if_pc=0.
  - Then 0x1000_0004 at if_pc=4 on the next cycle, and so on.
- Stall raised on the cycle data for PC 8 returns, held 3 cycles:
  - IF/ID holds PC 4 throughout; imem_req=0.
  - After release, IF/ID shows PC 8 then PC 12 on consecutive cycles; no gap, no duplicate.
- branch_taken with target 0x0000_0102 while streaming at PC 0x20:
  - Two cycles of if_valid=0 with ReadInstruction=0x0000_0013.
  - Next valid if_pc=0x100; PC 0x24 never appears.
- branch_taken during HOLD (stall=1): buffered word is discarded; after stall drops, next valid if_pc equals the target.
- PC_RESET=0xFFFF_FFF8: valid if_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted mid-stream with a pending request: outputs go to reset values at once, without waiting for a clock edge; after release, the fetch restarts at PC_RESET with 3-edge latency.
